// File: rtl/quad_decoder_if.sv
// Bundles the encoder inputs, enable and decoded pulse outputs of quad_decoder.
// The master side drives the encoder and enable; the slave side is the decoder.
interface quad_decoder_if;
  logic enable;
  logic enc_a;
  logic enc_b;
  logic inc_en;
  logic dec_en;
  logic err;
  logic err_sticky;
  logic dir;

  modport master (
    output enable, enc_a, enc_b,
    input  inc_en, dec_en, err, err_sticky, dir
  );

  modport slave (
    input  enable, enc_a, enc_b,
    output inc_en, dec_en, err, err_sticky, dir
  );
endinterface

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronizes and debounces A/B, then emits one
// registered inc/dec/err pulse per accepted change of the stable {a,b} state.
module quad_decoder #(
  parameter int FILTER_LEN  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           s_reset_n,
  quad_decoder_if.slave bus
);

  localparam int CntW = $clog2(FILTER_LEN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] syncA_q, syncB_q;
  logic [1:0][CntW-1:0] filtCnt_q, filtCnt_d;
  logic [CntW-1:0] initCnt_q, initCnt_d;
  logic [1:0] stable_q, stable_d;
  logic [1:0] prev_q, prev_d;
  logic incEn_q, incEn_d;
  logic decEn_q, decEn_d;
  logic err_q, err_d;
  logic sticky_q, sticky_d;
  logic dir_q, dir_d;

  logic [1:0] synced;
  logic [1:0] posPrev, posCur, delta;

  assign synced = {syncA_q[SYNC_STAGES-1], syncB_q[SYNC_STAGES-1]};

  // Gray-to-binary position so a forward step is +1 and a reverse step is -1 mod 4
  assign posPrev = {prev_q[1], prev_q[1] ^ prev_q[0]};
  assign posCur  = {stable_q[1], stable_q[1] ^ stable_q[0]};
  assign delta   = posCur - posPrev;

  always_comb begin
    state_d   = state_q;
    filtCnt_d = filtCnt_q;
    initCnt_d = initCnt_q;
    stable_d  = stable_q;
    prev_d    = prev_q;
    incEn_d   = 1'b0;
    decEn_d   = 1'b0;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    dir_d     = dir_q;

    case (state_q)
      INIT: begin
        if (initCnt_q == CntLast) begin
          stable_d  = synced;
          prev_d    = synced;
          initCnt_d = '0;
          state_d   = RUN;
        end else begin
          initCnt_d = initCnt_q + 1'b1;
        end
      end

      RUN: begin
        for (int ch = 0; ch < 2; ch++) begin
          if (synced[ch] != stable_q[ch]) begin
            if (filtCnt_q[ch] == CntLast) begin
              stable_d[ch]  = synced[ch];
              filtCnt_d[ch] = '0;
            end else begin
              filtCnt_d[ch] = filtCnt_q[ch] + 1'b1;
            end
          end else begin
            filtCnt_d[ch] = '0;
          end
        end

        // Tracking continues while disabled so no stale steps fire on re-enable
        prev_d = stable_q;
        if (bus.enable) begin
          case (delta)
            2'd1: begin
              incEn_d = 1'b1;
              dir_d   = 1'b1;
            end
            2'd3: begin
              decEn_d = 1'b1;
              dir_d   = 1'b0;
            end
            2'd2: begin
              err_d    = 1'b1;
              sticky_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!s_reset_n) begin
      state_q   <= INIT;
      syncA_q   <= '0;
      syncB_q   <= '0;
      filtCnt_q <= '0;
      initCnt_q <= '0;
      stable_q  <= 2'b00;
      prev_q    <= 2'b00;
      incEn_q   <= 1'b0;
      decEn_q   <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      dir_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      syncA_q   <= {syncA_q[SYNC_STAGES-2:0], bus.enc_a};
      syncB_q   <= {syncB_q[SYNC_STAGES-2:0], bus.enc_b};
      filtCnt_q <= filtCnt_d;
      initCnt_q <= initCnt_d;
      stable_q  <= stable_d;
      prev_q    <= prev_d;
      incEn_q   <= incEn_d;
      decEn_q   <= decEn_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      dir_q     <= dir_d;
    end
  end

  assign bus.inc_en     = incEn_q;
  assign bus.dec_en     = decEn_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.dir        = dir_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: stimulus pushes expected pulses (kind, cycle,
// dir) into a queue and a negedge monitor pops and compares every pulse seen.
module tb_quad_decoder;

  localparam int Lat = 7;
  localparam int KInc = 0;
  localparam int KDec = 1;
  localparam int KErr = 2;

  typedef struct {
    int   kind;
    int   cyc;
    logic dir;
  } exp_t;

  logic clk;
  logic s_reset_n;
  int   cycle;
  int   checks;
  int   failures;
  exp_t expQ[$];

  quad_decoder_if bus();

  quad_decoder #(
    .FILTER_LEN (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .s_reset_n(s_reset_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    int   nHigh;
    int   kind;
    exp_t e;
    nHigh = int'(bus.inc_en) + int'(bus.dec_en) + int'(bus.err);
    if (nHigh > 1) begin
      checks++;
      failures++;
      $display("[TB] FAIL exclusive cycle=%0d inc=%0b dec=%0b err=%0b required at most one high",
               cycle, bus.inc_en, bus.dec_en, bus.err);
    end else if (nHigh == 1) begin
      kind = bus.inc_en ? KInc : (bus.dec_en ? KDec : KErr);
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pulse cycle=%0d kind=%0d required none", cycle, kind);
      end else begin
        e = expQ.pop_front();
        if (kind != e.kind || cycle != e.cyc || bus.dir != e.dir) begin
          failures++;
          $display("[TB] FAIL pulse kind=%0d cycle=%0d dir=%0b required kind=%0d cycle=%0d dir=%0b",
                   kind, cycle, bus.dir, e.kind, e.cyc, e.dir);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Called #1 after a posedge; leaves the bench #1 after a later posedge
  task automatic applyStimulus(input logic a, input logic b, input int expKind,
                               input logic expDir, input int hold);
    exp_t e;
    bus.enc_a = a;
    bus.enc_b = b;
    if (expKind >= 0) begin
      e.kind = expKind;
      e.cyc  = cycle + Lat;
      e.dir  = expDir;
      expQ.push_back(e);
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cycle      = 0;
    checks     = 0;
    failures   = 0;
    s_reset_n  = 1'b0;
    bus.enable = 1'b1;
    bus.enc_a  = 1'b0;
    bus.enc_b  = 1'b0;

    waitCycles(2);
    checkOutput("reset_dir", int'(bus.dir), 1);
    checkOutput("reset_sticky", int'(bus.err_sticky), 0);
    s_reset_n = 1'b1;
    waitCycles(20);
    checkOutput("idle_dir", int'(bus.dir), 1);
    checkOutput("idle_sticky", int'(bus.err_sticky), 0);

    $display("[TB] forward detent");
    applyStimulus(1'b0, 1'b1, KInc, 1'b1, 20);
    applyStimulus(1'b1, 1'b1, KInc, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, KInc, 1'b1, 20);
    applyStimulus(1'b0, 1'b0, KInc, 1'b1, 20);
    checkOutput("fwd_dir", int'(bus.dir), 1);

    $display("[TB] reverse detent then one forward step");
    applyStimulus(1'b1, 1'b0, KDec, 1'b0, 20);
    applyStimulus(1'b1, 1'b1, KDec, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, KDec, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, KDec, 1'b0, 20);
    checkOutput("rev_dir", int'(bus.dir), 0);
    applyStimulus(1'b0, 1'b1, KInc, 1'b1, 20);
    checkOutput("fwd_again_dir", int'(bus.dir), 1);
    applyStimulus(1'b0, 1'b0, KDec, 1'b0, 20);

    $display("[TB] illegal double change");
    checkOutput("pre_err_sticky", int'(bus.err_sticky), 0);
    applyStimulus(1'b1, 1'b1, KErr, 1'b0, 20);
    checkOutput("err_sticky", int'(bus.err_sticky), 1);
    checkOutput("err_dir_held", int'(bus.dir), 0);

    $display("[TB] glitch rejection");
    applyStimulus(1'b0, 1'b1, -1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, -1, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, KDec, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, KInc, 1'b1, 20);
    checkOutput("glitch_dir", int'(bus.dir), 1);

    $display("[TB] enable gating");
    applyStimulus(1'b0, 1'b1, KDec, 1'b0, 20);
    bus.enable = 1'b0;
    applyStimulus(1'b1, 1'b1, -1, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, -1, 1'b0, 20);
    checkOutput("disabled_dir_held", int'(bus.dir), 0);
    checkOutput("disabled_sticky_held", int'(bus.err_sticky), 1);
    bus.enable = 1'b1;
    waitCycles(5);
    applyStimulus(1'b0, 1'b0, KInc, 1'b1, 20);
    checkOutput("reenable_dir", int'(bus.dir), 1);

    $display("[TB] reset mid-filter");
    applyStimulus(1'b0, 1'b1, -1, 1'b1, 3);
    s_reset_n = 1'b0;
    waitCycles(2);
    checkOutput("midreset_sticky", int'(bus.err_sticky), 0);
    checkOutput("midreset_dir", int'(bus.dir), 1);
    s_reset_n = 1'b1;
    waitCycles(20);
    applyStimulus(1'b1, 1'b1, KInc, 1'b1, 20);
    checkOutput("post_reset_dir", int'(bus.dir), 1);

    checkOutput("pending_pulses", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive cycles a synchronized channel must hold a new value before acceptance; legal 1..255.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per encoder channel; legal 2..4.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 s_reset_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  high = pulse generation allowed; low = outputs held at 0.
REQ-006 enc_a  input  1  encoder channel A, asynchronous to clk.
REQ-007 enc_b  input  1  encoder channel B, asynchronous to clk.
REQ-008 inc_en  output  1  one-cycle pulse per forward quadrature step; drives a counter's inc_en.
REQ-009 dec_en  output  1  one-cycle pulse per reverse quadrature step; drives a counter's dec_en.
REQ-010 err  output  1  one-cycle pulse on an illegal transition (both channels change on the same accepted update).
REQ-011 err_sticky  output  1  latched 1 after any err pulse; cleared only by reset.
REQ-012 dir  output  1  direction of last valid step: 1 forward, 0 reverse.

Function
REQ-013 Each channel passes through a SYNC_STAGES-deep flop chain before any other use.
REQ-014 Filter per channel: stable value updates on the edge where the synchronized value has differed from stable for FILTER_LEN consecutive cycles; any return to stable resets that channel's filter count to 0.
REQ-015 Filter counters are ceil(log2(FILTER_LEN+1)) bits wide and saturate, never wrap.
REQ-016 State machine: INIT, RUN.
REQ-017 INIT: entered on reset; after FILTER_LEN cycles, load synchronized {a,b} as both stable and previous state, no pulses, go to RUN.
REQ-018 RUN: each cycle, compare previous stable {a,b} with current stable {a,b}, then previous <= current.
REQ-019 Forward sequence 00->01->11->10->00: inc_en=1 for one cycle, dir=1.
REQ-020 Reverse sequence 00->10->11->01->00: dec_en=1 for one cycle, dir=0.
REQ-021 Both bits changed: err=1 for one cycle, err_sticky=1; no inc_en/dec_en; dir unchanged; previous state takes the new value.
REQ-022 No change: all pulses 0.
REQ-023 inc_en, dec_en, err are registered, mutually exclusive; never two high in one cycle.
REQ-024 Latency, edge changing at the synchronizer input to registered pulse: SYNC_STAGES + FILTER_LEN + 1 clock edges (7 at defaults).
REQ-025 Every accepted edge (x4 decode) produces exactly one pulse; one full detent cycle = 4 pulses.
REQ-026 enable=0: inc_en/dec_en/err forced to 0, dir and err_sticky held; synchronizer, filter and previous-state tracking continue, so re-asserting enable produces no pulse for steps taken while disabled.
REQ-027 Glitch shorter than FILTER_LEN cycles: no stable-state change, no pulse.

Reset
REQ-028 When s_reset_n=0 at a rising edge: state=INIT, filter counts=0, stable/previous=00, inc_en=0, dec_en=0, err=0, err_sticky=0, dir=1.
REQ-029 Reset takes priority over enable and all inputs; reset mid-step discards in-progress filter counts; no pulse emitted for the first stable state captured after reset.

Verification
REQ-030 Reset 2 cycles, enc_a=enc_b=0, enable=1, hold 20 cycles -> no pulses, err_sticky=0, dir=1.
REQ-031 Drive 00->01->11->10->00, each held 20 cycles -> exactly 4 inc_en pulses, each 7 edges after its input change, dec_en=0, dir=1.
REQ-032 Drive 00->10->11->01->00 -> exactly 4 dec_en pulses, dir=0; then one forward step -> 1 inc_en, dir=1.
REQ-033 From 00 step both channels to 11 in the same cycle -> one err pulse, err_sticky=1 until next reset, no inc_en/dec_en.
REQ-034 3-cycle glitch on enc_a (FILTER_LEN=4) -> no pulse; 4-cycle hold -> one pulse.
REQ-035 enable=0, two forward steps, enable=1 -> zero pulses; next forward step -> one inc_en; reset asserted mid-filter -> no pulse, state INIT.
